// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the multiport register file
package rf_pkg;
  localparam int WORD_SIZE_DEFAULT = 16;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int RF_ZERO_ADDR = 0;
  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits set at issue, cleared at writeback
module rf_scoreboard import rf_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter bit ZERO_REG = 1'b1,
  localparam int ADDR_W = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we0,
  input  logic [ADDR_W-1:0]   i_wa0,
  input  logic                i_we1,
  input  logic [ADDR_W-1:0]   i_wa1,
  input  logic                i_iss_en,
  input  logic [ADDR_W-1:0]   i_iss_rd,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [NUM_REGS-1:0] o_written,
  output logic                o_any_busy
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_issued;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dec
    assign o_written[g] = (i_we0 && i_wa0 == ADDR_W'(g)) || (i_we1 && i_wa1 == ADDR_W'(g));
    assign w_issued[g] = i_iss_en && i_iss_rd == ADDR_W'(g) && !(ZERO_REG && g == RF_ZERO_ADDR);
  end
  // a same-cycle issue outranks the writeback so the newer producer keeps the bit
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else r_busy <= (r_busy & ~o_written) | w_issued;
  end
  assign o_busy = r_busy;
  assign o_any_busy = |r_busy;
endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: NUM_READ bypassed read ports, two write ports, busy scoreboard
module multiport_register_file import rf_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int NUM_READ = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int ADDR_W = addr_width(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_READ*ADDR_W-1:0]    rs,
  output logic [NUM_READ*WORD_SIZE-1:0] rv,
  output logic [NUM_READ-1:0]           rv_busy,
  input  logic                          we0,
  input  logic [ADDR_W-1:0]             wa0,
  input  logic [WORD_SIZE-1:0]          wd0,
  input  logic                          we1,
  input  logic [ADDR_W-1:0]             wa1,
  input  logic [WORD_SIZE-1:0]          wd1,
  input  logic                          iss_en,
  input  logic [ADDR_W-1:0]             iss_rd,
  output logic                          any_busy
);
  logic [WORD_SIZE-1:0] r_mem [NUM_REGS];
  logic [NUM_REGS-1:0]  w_busy;
  logic [NUM_REGS-1:0]  w_written;
  logic                 w_wen0;
  logic                 w_wen1;
  assign w_wen0 = we0 && !(ZERO_REG && wa0 == ADDR_W'(RF_ZERO_ADDR));
  assign w_wen1 = we1 && !(ZERO_REG && wa1 == ADDR_W'(RF_ZERO_ADDR));
  rf_scoreboard #(.NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst(rst),
    .i_we0(we0),
    .i_wa0(wa0),
    .i_we1(we1),
    .i_wa1(wa1),
    .i_iss_en(iss_en),
    .i_iss_rd(iss_rd),
    .o_busy(w_busy),
    .o_written(w_written),
    .o_any_busy(any_busy)
  );
  // storage update; port 1 is written last so it wins an address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      if (w_wen0) r_mem[wa0] <= wd0;
      if (w_wen1) r_mem[wa1] <= wd1;
    end
  end
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] w_rs;
    logic              w_zero;
    assign w_rs = rs[k*ADDR_W +: ADDR_W];
    assign w_zero = ZERO_REG && w_rs == ADDR_W'(RF_ZERO_ADDR);
    assign rv[k*WORD_SIZE +: WORD_SIZE] = w_zero ? '0 :
                                          (we1 && wa1 == w_rs) ? wd1 :
                                          (we0 && wa0 == w_rs) ? wd0 : r_mem[w_rs];
    assign rv_busy[k] = !w_zero && w_busy[w_rs] && !w_written[w_rs];
  end
endmodule

// File: tb/tb_multiport_register_file.sv
// tb_multiport_register_file: queued-expectation scoreboard bench for the register file
module tb_multiport_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs0, rs1;
  logic [9:0]  rs;
  logic [31:0] rv;
  logic [1:0]  rv_busy;
  logic        we0, we1, iss_en, any_busy;
  logic [4:0]  wa0, wa1, iss_rd;
  logic [15:0] wd0, wd1;
  typedef struct {
    string       name;
    logic [15:0] rv0;
    logic [15:0] rv1;
    logic [1:0]  busy;
    logic        any;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  assign rs = {rs1, rs0};
  always #5 clk = ~clk;
  multiport_register_file #(.WORD_SIZE(16), .NUM_REGS(32), .NUM_READ(2), .ZERO_REG(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .rs(rs),
    .rv(rv),
    .rv_busy(rv_busy),
    .we0(we0),
    .wa0(wa0),
    .wd0(wd0),
    .we1(we1),
    .wa1(wa1),
    .wd1(wd1),
    .iss_en(iss_en),
    .iss_rd(iss_rd),
    .any_busy(any_busy)
  );
  // monitor: outputs are settled mid-cycle, compare against the oldest expectation
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (rv[15:0] !== e.rv0 || rv[31:16] !== e.rv1 || rv_busy !== e.busy || any_busy !== e.any) begin
        n_fail++;
        $display("FAIL %s: got rv0=%h rv1=%h busy=%b any=%b, expected rv0=%h rv1=%h busy=%b any=%b",
                 e.name, rv[15:0], rv[31:16], rv_busy, any_busy, e.rv0, e.rv1, e.busy, e.any);
      end
    end
  end
  task automatic push(input string n, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] bz, input logic an);
    exp_t e;
    e.name = n;
    e.rv0 = a;
    e.rv1 = b;
    e.busy = bz;
    e.any = an;
    q.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    rst = 1'b0;
    we0 = 1'b0;
    we1 = 1'b0;
    iss_en = 1'b0;
  endtask
  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_rd = '0; rs0 = '0; rs1 = '0;
    repeat (2) @(posedge clk);
    cyc(); push("reset_state", 16'h0, 16'h0, 2'b00, 1'b0);
    cyc(); we0 = 1; wa0 = 5; wd0 = 16'h1234; rs1 = 5; push("r5_bypass", 16'h0, 16'h1234, 2'b00, 1'b0);
    cyc(); rst = 1; push("r5_stored", 16'h0, 16'h1234, 2'b00, 1'b0);
    cyc(); push("r5_after_rst", 16'h0, 16'h0, 2'b00, 1'b0);
    cyc(); we0 = 1; wa0 = 3; wd0 = 16'hBEEF; rs0 = 3; push("r3_bypass", 16'hBEEF, 16'h0, 2'b00, 1'b0);
    cyc(); push("r3_held", 16'hBEEF, 16'h0, 2'b00, 1'b0);
    cyc(); we0 = 1; wa0 = 7; wd0 = 16'h1111; we1 = 1; wa1 = 7; wd1 = 16'h2222; rs0 = 7; rs1 = 3;
    push("collision_bypass", 16'h2222, 16'hBEEF, 2'b00, 1'b0);
    cyc(); we0 = 1; wa0 = 0; wd0 = 16'hFFFF; iss_en = 1; iss_rd = 0; rs1 = 0;
    push("collision_stored_r0_write", 16'h2222, 16'h0, 2'b00, 1'b0);
    cyc(); push("r0_zero_no_busy", 16'h2222, 16'h0, 2'b00, 1'b0);
    cyc(); iss_en = 1; iss_rd = 9; rs0 = 9; push("r9_issue_latency", 16'h0, 16'h0, 2'b00, 1'b0);
    cyc(); rs1 = 9; push("r9_busy", 16'h0, 16'h0, 2'b11, 1'b1);
    cyc(); we1 = 1; wa1 = 9; wd1 = 16'h00AA; rs1 = 3; push("r9_writeback", 16'h00AA, 16'hBEEF, 2'b00, 1'b1);
    cyc(); push("r9_clear", 16'h00AA, 16'hBEEF, 2'b00, 1'b0);
    cyc(); iss_en = 1; iss_rd = 4; rs0 = 4; push("r4_issue", 16'h0, 16'hBEEF, 2'b00, 1'b0);
    cyc(); iss_en = 1; iss_rd = 4; we0 = 1; wa0 = 4; wd0 = 16'h4444;
    push("r4_issue_and_wb", 16'h4444, 16'hBEEF, 2'b00, 1'b1);
    cyc(); push("r4_still_busy", 16'h4444, 16'hBEEF, 2'b01, 1'b1);
    cyc(); we0 = 1; wa0 = 4; wd0 = 16'h5555; push("r4_wb", 16'h5555, 16'hBEEF, 2'b00, 1'b1);
    cyc(); push("r4_clear", 16'h5555, 16'hBEEF, 2'b00, 1'b0);
    cyc(); iss_en = 1; iss_rd = 2; rs0 = 2; push("r2_issue", 16'h0, 16'hBEEF, 2'b00, 1'b0);
    cyc(); rst = 1; we0 = 1; wa0 = 2; wd0 = 16'h7777; push("r2_rst_cycle", 16'h7777, 16'hBEEF, 2'b00, 1'b1);
    cyc(); push("r2_after_rst", 16'h0, 16'h0, 2'b00, 1'b0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
